demux_rr_dispatcher: RTL and testbench

//  Sequencer for the 1-to-8 demux datapath. Accepts words from one valid/ready

---
 rtl/demux_rr_dispatcher.sv | 109 ++++++++++
 tb/tb_demux_rr_dispatcher.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher
//   Sequencer for the 1-to-8 demux datapath. Takes words from a single
//   valid/ready source, holds one word at a time and presents it to exactly
//   one of 8 sinks through a 3-bit select and a one-hot per-channel valid.
//   The target is either the round-robin pointer (with timeout-skip of a
//   stalled sink) or a fixed channel.
//
//   state | meaning
//   ------+------------------------------------------
//   IDLE  | holding register empty, source may write
//   HOLD  | holding register full, word presented on ch_valid[sel]
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset; also gates in_ready/ch_valid/busy
//   in_valid  source word valid
//   in_data   source word
//   in_ready  dispatcher accepts a word this cycle
//   mode      0 = round-robin, 1 = fixed channel (sampled at capture only)
//   fix_sel   fixed target channel (sampled at capture only)
//   ch_ready  per-sink ready; only ch_ready[sel] is looked at
//   ch_valid  one-hot valid for the selected sink
//   ch_data   held word, shared bus to all sinks
//   sel       demux select of the held word
//   busy      holding register occupied
//   skip_cnt  saturating count of timeout skips
module demux_rr_dispatcher #(
    parameter int DATA_W   = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              mode,
    input  logic [2:0]        fix_sel,
    input  logic [7:0]        ch_ready,
    output logic [7:0]        ch_valid,
    output logic [DATA_W-1:0] ch_data,
    output logic [2:0]        sel,
    output logic              busy,
    output logic [7:0]        skip_cnt
);

    typedef enum logic {IDLE, HOLD} state_t;

    // Stall timer is a down-counter: loaded with HOLD_MAX-1 on capture/skip,
    // terminal count 0 on a stalled cycle triggers the skip.
    localparam int              TMR_W    = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
    localparam logic            SKIP_EN  = (HOLD_MAX > 0);

    state_t           state;
    logic             held_rr;     // held word was captured in round-robin mode
    logic [TMR_W-1:0] hold_tmr;
    logic [2:0]       rr_ptr;

    logic       holding;
    logic       deliver;
    logic       capture;
    logic       skip;
    logic [2:0] rr_ptr_nxt;

    assign holding  = rst_n && (state == HOLD);
    assign deliver  = holding && ch_ready[sel];
    assign in_ready = rst_n && ((state == IDLE) || deliver);
    assign capture  = in_valid && in_ready;
    assign skip     = holding && !deliver && held_rr && SKIP_EN && (hold_tmr == '0);

    // Advanced pointer is visible to a back-to-back capture in the same cycle.
    assign rr_ptr_nxt = (deliver && held_rr) ? sel + 3'd1 : rr_ptr;

    assign ch_valid = holding ? (8'b1 << sel) : 8'b0;
    assign busy     = holding;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= 3'd0;
            rr_ptr   <= 3'd0;
            hold_tmr <= '0;
            held_rr  <= 1'b0;
            ch_data  <= '0;
            skip_cnt <= 8'd0;
        end else begin
            rr_ptr <= rr_ptr_nxt;
            if (capture) begin
                state    <= HOLD;
                ch_data  <= in_data;
                sel      <= mode ? fix_sel : rr_ptr_nxt;
                held_rr  <= !mode;
                hold_tmr <= TMR_LOAD;
            end else if (deliver) begin
                state <= IDLE;
            end else if (skip) begin
                // word is kept, only its destination moves on
                sel      <= sel + 3'd1;
                hold_tmr <= TMR_LOAD;
                if (skip_cnt != 8'hFF) begin
                    skip_cnt <= skip_cnt + 8'd1;
                end
            end else if (holding && (hold_tmr != '0)) begin
                hold_tmr <= hold_tmr - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
module tb_demux_rr_dispatcher;

    typedef struct {
        logic       rst_n;
        logic       in_valid;
        logic [7:0] in_data;
        logic       mode;
        logic [2:0] fix_sel;
        logic [7:0] ch_ready;
        logic       exp_ready;
        logic [7:0] exp_valid;
        logic [2:0] exp_sel;
        logic [7:0] exp_data;
        logic [7:0] exp_skip;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mode;
    logic [2:0] fix_sel;
    logic [7:0] ch_ready;
    logic [7:0] ch_valid;
    logic [7:0] ch_data;
    logic [2:0] sel;
    logic       busy;
    logic [7:0] skip_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t tbl[$];

    demux_rr_dispatcher #(.DATA_W(8), .HOLD_MAX(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mode     (mode),
        .fix_sel  (fix_sel),
        .ch_ready (ch_ready),
        .ch_valid (ch_valid),
        .ch_data  (ch_data),
        .sel      (sel),
        .busy     (busy),
        .skip_cnt (skip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int step, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s step %0d: actual %0h required %0h", name, step, act, exp);
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                                input logic m, input logic [2:0] f, input logic [7:0] rdy,
                                input logic er, input logic [7:0] ev, input logic [2:0] es,
                                input logic [7:0] ed, input logic [7:0] esk);
        vec_t t;
        t.rst_n = r; t.in_valid = v; t.in_data = d; t.mode = m; t.fix_sel = f;
        t.ch_ready = rdy; t.exp_ready = er; t.exp_valid = ev; t.exp_sel = es;
        t.exp_data = ed; t.exp_skip = esk;
        return t;
    endfunction

    // drive on the falling edge, compare 1 time unit later (well before the rising edge)
    task automatic apply(input vec_t t, input int step);
        @(negedge clk);
        rst_n = t.rst_n; in_valid = t.in_valid; in_data = t.in_data;
        mode = t.mode; fix_sel = t.fix_sel; ch_ready = t.ch_ready;
        #1;
        chk("in_ready", step, int'(in_ready), int'(t.exp_ready));
        chk("ch_valid", step, int'(ch_valid), int'(t.exp_valid));
        chk("busy",     step, int'(busy),     int'(t.exp_valid != 8'h00));
        chk("sel",      step, int'(sel),      int'(t.exp_sel));
        chk("ch_data",  step, int'(ch_data),  int'(t.exp_data));
        chk("skip_cnt", step, int'(skip_cnt), int'(t.exp_skip));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        mode = 1'b0; fix_sel = 3'd0; ch_ready = 8'h00;

        // reset state, checked while rst_n is still low
        tbl.push_back(mk(0, 1, 8'h33, 0, 0, 8'hFF, 0, 8'h00, 0, 8'h00, 0));

        // RR back-to-back, all sinks ready: 10 words 0x00..0x09
        tbl.push_back(mk(1, 1, 8'h00, 0, 0, 8'hFF, 1, 8'h00, 0, 8'h00, 0));
        for (int k = 1; k <= 9; k++)
            tbl.push_back(mk(1, 1, 8'(k), 0, 0, 8'hFF, 1,
                             8'h01 << ((k - 1) % 8), 3'((k - 1) % 8), 8'(k - 1), 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'hFF, 1, 8'h02, 1, 8'h09, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'hFF, 1, 8'h00, 1, 8'h09, 0));

        // fixed channel 5 stalled for 20 cycles, no skips, then released
        tbl.push_back(mk(1, 1, 8'hAA, 1, 5, 8'hDF, 1, 8'h00, 1, 8'h09, 0));
        for (int k = 0; k < 20; k++)
            tbl.push_back(mk(1, 1, 8'hBB, 1, 5, 8'hDF, 0, 8'h20, 5, 8'hAA, 0));
        tbl.push_back(mk(1, 1, 8'hBB, 1, 5, 8'hFF, 1, 8'h20, 5, 8'hAA, 0));
        tbl.push_back(mk(1, 0, 8'h00, 1, 5, 8'hFF, 1, 8'h20, 5, 8'hBB, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'hFF, 1, 8'h00, 5, 8'hBB, 0));

        @(negedge clk);
        foreach (tbl[i]) apply(tbl[i], i);

        // RR word to channel 2 (rr_ptr=2) stalls, skips to 3, then reset mid-HOLD
        apply(mk(1, 1, 8'h5A, 0, 0, 8'h00, 1, 8'h00, 5, 8'hBB, 0), 100);
        for (int k = 0; k < 4; k++)
            apply(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h04, 2, 8'h5A, 0), 101 + k);
        apply(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h08, 3, 8'h5A, 1), 105);
        apply(mk(0, 1, 8'h77, 0, 0, 8'hFF, 0, 8'h00, 3, 8'h5A, 1), 106);
        apply(mk(1, 0, 8'h00, 0, 0, 8'hFE, 1, 8'h00, 0, 8'h00, 0), 107);

        // timeout skip from rr_ptr=0 with channel 0 stuck, next word goes to 2
        apply(mk(1, 1, 8'hC0, 0, 0, 8'hFE, 1, 8'h00, 0, 8'h00, 0), 200);
        for (int k = 0; k < 4; k++)
            apply(mk(1, 0, 8'h00, 0, 0, 8'hFE, 0, 8'h01, 0, 8'hC0, 0), 201 + k);
        apply(mk(1, 1, 8'hC1, 0, 0, 8'hFE, 1, 8'h02, 1, 8'hC0, 1), 205);
        apply(mk(1, 0, 8'h00, 0, 0, 8'hFE, 1, 8'h04, 2, 8'hC1, 1), 206);

        // mode flips to fixed while an RR word is held; fixed delivery keeps rr_ptr
        apply(mk(1, 1, 8'hD0, 0, 0, 8'h00, 1, 8'h00, 2, 8'hC1, 1), 300);
        apply(mk(1, 0, 8'h00, 1, 6, 8'h00, 0, 8'h08, 3, 8'hD0, 1), 301);
        apply(mk(1, 1, 8'hD1, 1, 6, 8'h08, 1, 8'h08, 3, 8'hD0, 1), 302);
        apply(mk(1, 0, 8'h00, 1, 6, 8'h40, 1, 8'h40, 6, 8'hD1, 1), 303);
        apply(mk(1, 1, 8'hD2, 0, 0, 8'hFF, 1, 8'h00, 6, 8'hD1, 1), 304);
        apply(mk(1, 0, 8'h00, 0, 0, 8'hFF, 1, 8'h10, 4, 8'hD2, 1), 305);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
